// File: rtl/rvfi_imem_shadow_check.sv
// rtl/rvfi_imem_shadow_check.sv - RVFI instruction-memory shadow checker; RVFI_IMEM_FENCEI_EN lets FENCE.I forget learned halfwords
module rvfi_imem_shadow_check #(
    parameter int XLEN = 32,
    parameter int NRET = 1,
    parameter int NENT = 4,
    parameter int CNTW = 16
) (
    input  logic                                   clk,
    input  logic                                   resetn,
    input  logic [NENT*XLEN-1:0]                   track_addr,
    input  logic [NRET-1:0]                        rvfi_valid,
    input  logic [NRET-1:0]                        rvfi_trap,
    input  logic [NRET*32-1:0]                     rvfi_insn,
    input  logic [NRET*XLEN-1:0]                   rvfi_pc_rdata,
    output logic [NENT-1:0]                        learned,
    output logic                                   err,
    output logic [((NENT > 1) ? $clog2(NENT) : 1)-1:0] err_entry,
    output logic [15:0]                            err_exp,
    output logic [15:0]                            err_got,
    output logic [CNTW-1:0]                        check_cnt
);
    localparam int EW = (NENT > 1) ? $clog2(NENT) : 1;
    localparam int SW = CNTW + 32;

    logic [NENT-1:0]  learned_d;
    logic [15:0]      data_q [NENT];
    logic [15:0]      data_d [NENT];
    logic [31:0]      inc;
    logic             mismatch;
    logic [EW-1:0]    mm_entry;
    logic [15:0]      mm_exp;
    logic [15:0]      mm_got;
    logic [XLEN-2:0]  pc_h;
    logic [XLEN-2:0]  pc_hi_h;
    logic [31:0]      insn;
    logic             hit;
    logic [15:0]      hw;
    logic [SW-1:0]    cnt_sum;
    logic [CNTW-1:0]  cnt_next;
    logic             unused_lsbs;

    // Addresses are halfword-granular: only bits [XLEN-1:1] take part in compares.
    always_comb begin
        unused_lsbs = 1'b0;
        for (int e = 0; e < NENT; e++) unused_lsbs = unused_lsbs ^ track_addr[e*XLEN];
        for (int c = 0; c < NRET; c++) unused_lsbs = unused_lsbs ^ rvfi_pc_rdata[c*XLEN];
    end

    always_comb begin
        learned_d = learned;
        for (int e = 0; e < NENT; e++) data_d[e] = data_q[e];
        inc      = '0;
        mismatch = 1'b0;
        mm_entry = '0;
        mm_exp   = '0;
        mm_got   = '0;
        pc_h     = '0;
        pc_hi_h  = '0;
        insn     = '0;
        hit      = 1'b0;
        hw       = '0;
        for (int c = 0; c < NRET; c++) begin
            if (rvfi_valid[c] && !rvfi_trap[c]) begin
                pc_h    = rvfi_pc_rdata[c*XLEN+1 +: XLEN-1];
                pc_hi_h = pc_h + 1'b1;
                insn    = rvfi_insn[c*32 +: 32];
                // k=0 is the low-halfword pass, k=1 the high-halfword pass.
                for (int k = 0; k < 2; k++) begin
                    for (int e = 0; e < NENT; e++) begin
                        if (k == 0) begin
                            hit = (pc_h == track_addr[e*XLEN+1 +: XLEN-1]);
                            hw  = insn[15:0];
                        end else begin
                            hit = (insn[1:0] == 2'b11) && (pc_hi_h == track_addr[e*XLEN+1 +: XLEN-1]);
                            hw  = insn[31:16];
                        end
                        if (hit) begin
                            if (!learned_d[e]) begin
                                learned_d[e] = 1'b1;
                                data_d[e]    = hw;
                            end else begin
                                inc = inc + 32'd1;
                                if (hw != data_d[e]) begin
                                    if (!mismatch) begin
                                        mm_entry = EW'(e);
                                        mm_exp   = data_d[e];
                                        mm_got   = hw;
                                    end
                                    mismatch = 1'b1;
                                end
                            end
                        end
                    end
                end
`ifdef RVFI_IMEM_FENCEI_EN
                if (insn[6:0] == 7'b0001111 && insn[14:12] == 3'b001) learned_d = '0;
`endif
            end
        end
        cnt_sum  = SW'(check_cnt) + SW'(inc);
        cnt_next = (cnt_sum > SW'({CNTW{1'b1}})) ? {CNTW{1'b1}} : cnt_sum[CNTW-1:0];
    end

`ifdef FORMAL
    always_comb begin
        if (resetn) assert (!mismatch);
    end
`endif

    always_ff @(posedge clk) begin
        if (!resetn) begin
            learned   <= '0;
            err       <= 1'b0;
            err_entry <= '0;
            err_exp   <= '0;
            err_got   <= '0;
            check_cnt <= '0;
            for (int e = 0; e < NENT; e++) data_q[e] <= '0;
        end else begin
            learned   <= learned_d;
            check_cnt <= cnt_next;
            for (int e = 0; e < NENT; e++) data_q[e] <= data_d[e];
            if (mismatch && !err) begin
                err       <= 1'b1;
                err_entry <= mm_entry;
                err_exp   <= mm_exp;
                err_got   <= mm_got;
            end
        end
    end
endmodule

// File: tb/tb_rvfi_imem_shadow_check.sv
// tb/tb_rvfi_imem_shadow_check.sv - directed bench with a hit-list reference model for rvfi_imem_shadow_check
module tb_rvfi_imem_shadow_check;
    localparam int XLEN = 32;
    localparam int NRET = 2;
    localparam int NENT = 4;
    localparam int CNTW = 4;

    logic                 clk;
    logic                 resetn;
    logic [NENT*XLEN-1:0] track_addr;
    logic [NRET-1:0]      rvfi_valid;
    logic [NRET-1:0]      rvfi_trap;
    logic [NRET*32-1:0]   rvfi_insn;
    logic [NRET*XLEN-1:0] rvfi_pc_rdata;
    logic [NENT-1:0]      learned;
    logic                 err;
    logic [1:0]           err_entry;
    logic [15:0]          err_exp;
    logic [15:0]          err_got;
    logic [CNTW-1:0]      check_cnt;

    rvfi_imem_shadow_check #(.XLEN(XLEN), .NRET(NRET), .NENT(NENT), .CNTW(CNTW)) dut (
        .clk(clk), .resetn(resetn), .track_addr(track_addr),
        .rvfi_valid(rvfi_valid), .rvfi_trap(rvfi_trap), .rvfi_insn(rvfi_insn),
        .rvfi_pc_rdata(rvfi_pc_rdata), .learned(learned), .err(err),
        .err_entry(err_entry), .err_exp(err_exp), .err_got(err_got), .check_cnt(check_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic cmp_on = 1'b0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: list each channel's hits in priority order, then walk the list.
    logic [NENT-1:0] m_learned;
    logic [15:0]     m_data [NENT];
    int              m_cnt;
    logic            m_err;
    int              m_entry;
    logic [15:0]     m_exp, m_got;
    int              qe[$];
    logic [15:0]     qh[$];
    logic [31:0]     m_pc, m_insn, m_a;
    int              m_n;

    always @(posedge clk) begin
        if (!resetn) begin
            m_learned = '0;
            for (int e = 0; e < NENT; e++) m_data[e] = '0;
            m_cnt = 0; m_err = 0; m_entry = 0; m_exp = '0; m_got = '0;
        end else begin
            m_n = 0;
            for (int c = 0; c < NRET; c++) begin
                if (rvfi_valid[c] && !rvfi_trap[c]) begin
                    m_pc = rvfi_pc_rdata[c*32 +: 32];
                    m_insn = rvfi_insn[c*32 +: 32];
                    qe.delete(); qh.delete();
                    for (int e = 0; e < NENT; e++) begin
                        m_a = track_addr[e*32 +: 32];
                        if ((m_pc >> 1) == (m_a >> 1)) begin qe.push_back(e); qh.push_back(m_insn[15:0]); end
                    end
                    if (m_insn[1:0] == 2'b11)
                        for (int e = 0; e < NENT; e++) begin
                            m_a = track_addr[e*32 +: 32];
                            if (((m_pc + 32'd2) >> 1) == (m_a >> 1)) begin qe.push_back(e); qh.push_back(m_insn[31:16]); end
                        end
                    for (int i = 0; i < qe.size(); i++) begin
                        if (!m_learned[qe[i]]) begin
                            m_learned[qe[i]] = 1'b1;
                            m_data[qe[i]] = qh[i];
                        end else begin
                            m_n++;
                            if (qh[i] != m_data[qe[i]] && !m_err) begin
                                m_err = 1; m_entry = qe[i]; m_exp = m_data[qe[i]]; m_got = qh[i];
                            end
                        end
                    end
`ifdef RVFI_IMEM_FENCEI_EN
                    if (m_insn[6:0] == 7'h0F && m_insn[14:12] == 3'b001) m_learned = '0;
`endif
                end
            end
            m_cnt = (m_cnt + m_n > 15) ? 15 : m_cnt + m_n;
        end
    end

    always @(negedge clk) begin
        if (cmp_on) begin
            chk("learned", 32'(learned), 32'(m_learned));
            chk("err", 32'(err), 32'(m_err));
            chk("err_entry", 32'(err_entry), 32'(m_entry));
            chk("err_exp", 32'(err_exp), 32'(m_exp));
            chk("err_got", 32'(err_got), 32'(m_got));
            chk("check_cnt", 32'(check_cnt), 32'(m_cnt));
        end
    end

    task automatic cyc(input logic v0, input logic t0, input logic [31:0] pc0, input logic [31:0] i0,
                       input logic v1, input logic t1, input logic [31:0] pc1, input logic [31:0] i1);
        rvfi_valid = {v1, v0};
        rvfi_trap = {t1, t0};
        rvfi_pc_rdata = {pc1, pc0};
        rvfi_insn = {i1, i0};
        @(negedge clk);
    endtask

    task automatic one(input logic [31:0] pc, input logic [31:0] insn);
        cyc(1, 0, pc, insn, 0, 0, 32'h0, 32'h0);
    endtask

    task automatic idle();
        cyc(0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0);
    endtask

    initial begin
        resetn = 1'b0;
        track_addr = {32'h300, 32'h200, 32'h0, 32'h100};
        rvfi_valid = '0; rvfi_trap = '0; rvfi_insn = '0; rvfi_pc_rdata = '0;
        @(negedge clk);
        cmp_on = 1'b1;
        idle();
        chk("rst_learned", 32'(learned), 32'h0);
        chk("rst_cnt", 32'(check_cnt), 32'h0);
        chk("rst_err", 32'(err), 32'h0);
        resetn = 1'b1;

        one(32'h100, 32'h00000013);
        chk("t1_learned", 32'(learned), 32'h1);
        chk("t1_cnt", 32'(check_cnt), 32'h0);
        one(32'h100, 32'h00000013);
        chk("t2_cnt", 32'(check_cnt), 32'h1);
        chk("t2_err", 32'(err), 32'h0);
        one(32'h100, 32'h00000093);
        chk("t3_err", 32'(err), 32'h1);
        chk("t3_entry", 32'(err_entry), 32'h0);
        chk("t3_exp", 32'(err_exp), 32'h0013);
        chk("t3_got", 32'(err_got), 32'h0093);
        one(32'h100, 32'h00000113);
        chk("t3_got_kept", 32'(err_got), 32'h0093);
        chk("t3_cnt", 32'(check_cnt), 32'h3);
        one(32'hFFFFFFFE, 32'h12345677);
        chk("t4_learned", 32'(learned), 32'h3);
        one(32'hFFFFFFFE, 32'h00000001);
        chk("t4_cnt_nohit", 32'(check_cnt), 32'h3);
        one(32'h0, 32'h00001234);
        chk("t4_cnt_match", 32'(check_cnt), 32'h4);
        chk("t4_err_entry", 32'(err_entry), 32'h0);

        resetn = 1'b0;
        idle();
        resetn = 1'b1;
        chk("r2_err", 32'(err), 32'h0);
        cyc(1, 0, 32'h200, 32'h00A00093, 1, 0, 32'h200, 32'h00B00093);
        chk("t5_learned", 32'(learned), 32'h4);
        chk("t5_cnt", 32'(check_cnt), 32'h1);
        chk("t5_err", 32'(err), 32'h0);
        cyc(0, 0, 32'h0, 32'h0, 1, 1, 32'h200, 32'h00000013);
        chk("t5_trap_cnt", 32'(check_cnt), 32'h1);
        chk("t5_trap_err", 32'(err), 32'h0);

        one(32'h100, 32'h00000013);
        chk("t6_learned", 32'(learned), 32'h5);
        one(32'h400, 32'h0000100F);
`ifdef RVFI_IMEM_FENCEI_EN
        chk("t6_fence_learned", 32'(learned), 32'h0);
`else
        chk("t6_fence_learned", 32'(learned), 32'h5);
`endif
        one(32'h100, 32'h00000093);
`ifdef RVFI_IMEM_FENCEI_EN
        chk("t6_relearn", 32'(learned), 32'h1);
        chk("t6_err", 32'(err), 32'h0);
`else
        chk("t6_err", 32'(err), 32'h1);
        chk("t6_got", 32'(err_got), 32'h0093);
`endif

        resetn = 1'b0;
        one(32'h100, 32'h00000013);
        chk("mid_rst_err", 32'(err), 32'h0);
        chk("mid_rst_learned", 32'(learned), 32'h0);
        chk("mid_rst_cnt", 32'(check_cnt), 32'h0);
        chk("mid_rst_got", 32'(err_got), 32'h0);
        track_addr = {32'h500, 32'h302, 32'h300, 32'h300};
        idle();
        resetn = 1'b1;

        one(32'h300, 32'hAAAABBBB);
        chk("dup_learned", 32'(learned), 32'h7);
        chk("dup_cnt", 32'(check_cnt), 32'h0);
        cyc(1, 0, 32'h300, 32'hCCCCDDDF, 1, 0, 32'h302, 32'h00001111);
        chk("prio_err", 32'(err), 32'h1);
        chk("prio_entry", 32'(err_entry), 32'h0);
        chk("prio_exp", 32'(err_exp), 32'hBBBB);
        chk("prio_got", 32'(err_got), 32'hDDDF);
        chk("prio_cnt", 32'(check_cnt), 32'h4);
        cyc(1, 0, 32'h300, 32'hAAAABBBB, 1, 0, 32'h300, 32'hAAAABBBB);
        chk("sat_pre", 32'(check_cnt), 32'hA);
        cyc(1, 0, 32'h300, 32'hAAAABBBB, 1, 0, 32'h300, 32'hAAAABBBB);
        chk("sat_cnt", 32'(check_cnt), 32'hF);
        chk("sat_got_kept", 32'(err_got), 32'hDDDF);
        idle();

        cmp_on = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
